// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : round-robin arbiter with bounded burst lock in front of data_mem
// Revision    : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int D        = 8,
  parameter int W        = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic         lock0,
  input  logic         lock1,
  input  logic [D-1:0] addr0,
  input  logic [D-1:0] addr1,
  input  logic [W-1:0] wdata0,
  input  logic [W-1:0] wdata1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic [W-1:0] rdata0,
  output logic [W-1:0] rdata1,
  output logic         mem_read,
  output logic         mem_write,
  output logic [D-1:0] mem_addr,
  output logic [W-1:0] mem_din,
  input  logic [W-1:0] mem_dout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] lock_cnt, cnt_nxt;
  logic          rd0, rd1;

  // Grant selection: an owner keeps the port until its lock budget runs out
  // while the other side waits; otherwise plain round-robin on 'last'.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (state == OWN0 && req0) begin
        if (lock_cnt == CNT_MAX && req1) gnt1 = 1'b1;
        else                             gnt0 = 1'b1;
      end else if (state == OWN1 && req1) begin
        if (lock_cnt == CNT_MAX && req0) gnt0 = 1'b1;
        else                             gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (last) gnt0 = 1'b1;
        else      gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    last_nxt  = last;
    cnt_nxt   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (gnt0) begin
      last_nxt  = 1'b0;
      state_nxt = lock0 ? OWN0 : IDLE;
      if (state == OWN0 && req1) cnt_nxt = lock_cnt + CNT_ONE;
      mem_read  = ~we0;
      mem_write = we0;
      mem_addr  = addr0;
      mem_din   = wdata0;
    end else if (gnt1) begin
      last_nxt  = 1'b1;
      state_nxt = lock1 ? OWN1 : IDLE;
      if (state == OWN1 && req0) cnt_nxt = lock_cnt + CNT_ONE;
      mem_read  = ~we1;
      mem_write = we1;
      mem_addr  = addr1;
      mem_din   = wdata1;
    end
  end

  assign rd0 = gnt0 & ~we0;
  assign rd1 = gnt1 & ~we1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= cnt_nxt;
      rvalid0  <= rd0;
      rvalid1  <= rd1;
      if (rd0) rdata0 <= mem_dout;
      if (rd1) rdata1 <= mem_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter : directed vectors with a queue-based scoreboard for mem_arbiter
module tb_mem_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_read, mem_write;
  logic [7:0] mem_addr, mem_din, mem_dout;

  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (pre_we)         mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_addr] <= mem_din;
  end

  mem_arbiter #(.D(8), .W(8), .LOCK_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // exp = {gnt0, gnt1, mem_read, mem_write, rvalid0, rvalid1, mem_addr, mem_din}
  typedef struct {
    int          id;
    logic [21:0] exp;
    logic        zchk;
    logic        echk;
  } exp_t;

  exp_t       gq[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         checks   = 0;
  int         failures = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [21:0] act;
    logic [7:0]  d;
    if (rvalid0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL rd0: unexpected rvalid0, rdata0=%h, required no read", rdata0);
      end else begin
        d = q0.pop_front();
        if (rdata0 !== d) begin
          failures++;
          $display("FAIL rd0: rdata0=%h required %h", rdata0, d);
        end
      end
    end
    if (rvalid1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL rd1: unexpected rvalid1, rdata1=%h, required no read", rdata1);
      end else begin
        d = q1.pop_front();
        if (rdata1 !== d) begin
          failures++;
          $display("FAIL rd1: rdata1=%h required %h", rdata1, d);
        end
      end
    end
    if (gq.size() != 0) begin
      e   = gq.pop_front();
      act = {gnt0, gnt1, mem_read, mem_write, rvalid0, rvalid1, mem_addr, mem_din};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL ctl step %0d: {g0 g1 rd wr rv0 rv1}=%b addr=%h din=%h, required %b addr=%h din=%h",
                 e.id, act[21:16], act[15:8], act[7:0], e.exp[21:16], e.exp[15:8], e.exp[7:0]);
      end
      if (e.zchk) begin
        checks++;
        if ({rdata0, rdata1} !== 16'h0000) begin
          failures++;
          $display("FAIL reset_rdata step %0d: rdata0=%h rdata1=%h required 00 00", e.id, rdata0, rdata1);
        end
      end
      if (e.echk) begin
        checks++;
        if (q0.size() + q1.size() != 0) begin
          failures++;
          $display("FAIL drain: %0d reads never returned, required 0", q0.size() + q1.size());
        end
      end
    end
  end

  logic prv0, prv1, zflag, eflag;
  int   sid;

  task automatic step(input logic rn, r0, w0, l0, input logic [7:0] a0, d0,
                      input logic r1, w1, l1, input logic [7:0] a1, d1,
                      input logic eg0, eg1, input logic [7:0] ed0, ed1);
    exp_t       e;
    logic [7:0] ea, edin;
    rst_n = rn;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    ea   = eg0 ? a0 : (eg1 ? a1 : 8'h00);
    edin = eg0 ? d0 : (eg1 ? d1 : 8'h00);
    e.id   = sid;
    e.exp  = {eg0, eg1, (eg0 & ~w0) | (eg1 & ~w1), (eg0 & w0) | (eg1 & w1), prv0, prv1, ea, edin};
    e.zchk = zflag;
    e.echk = eflag;
    sid++;
    gq.push_back(e);
    if (eg0 && !w0) q0.push_back(ed0);
    if (eg1 && !w1) q1.push_back(ed1);
    prv0 = eg0 & ~w0;
    prv1 = eg1 & ~w1;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pa [5];
  logic [7:0] pd [5];

  initial begin
    pa = '{8'h12, 8'h20, 8'h21, 8'h30, 8'h31};
    pd = '{8'hA5, 8'h11, 8'h22, 8'h77, 8'h88};
    rst_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    prv0 = 0; prv1 = 0; zflag = 0; eflag = 0; sid = 0;
    pre_we = 1'b1; pre_addr = 0; pre_data = 0;
    for (int i = 0; i < 5; i++) begin
      pre_addr = pa[i];
      pre_data = pd[i];
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;

    // Reset held with both ports requesting
    zflag = 1;
    repeat (3) step(0, 1,0,0,8'h12,8'h00, 1,0,0,8'h20,8'h00, 0,0, 8'h00,8'h00);
    zflag = 0;

    // Contention right after reset: 0,1,0,1
    step(1, 1,0,0,8'h20,8'hAA, 1,0,0,8'h21,8'hBB, 1,0, 8'h11,8'h00);
    step(1, 1,0,0,8'h20,8'hAA, 1,0,0,8'h21,8'hBB, 0,1, 8'h00,8'h22);
    step(1, 1,0,0,8'h20,8'hAA, 1,0,0,8'h21,8'hBB, 1,0, 8'h11,8'h00);
    step(1, 1,0,0,8'h20,8'hAA, 1,0,0,8'h21,8'hBB, 0,1, 8'h00,8'h22);

    // Single read on port 0
    step(1, 1,0,0,8'h12,8'h00, 0,0,0,8'h00,8'h00, 1,0, 8'hA5,8'h00);
    step(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 8'h00,8'h00);

    // Port 1 locked alone, then port 0 waits out LOCK_MAX
    for (int i = 0; i < 20; i++)
      step(1, 0,0,0,8'h00,8'h00, 1,0,1,8'h30,8'h00, 0,1, 8'h00,8'h77);
    for (int i = 0; i < 16; i++)
      step(1, 1,0,0,8'h31,8'h00, 1,0,1,8'h30,8'h00, 0,1, 8'h00,8'h77);
    step(1, 1,0,0,8'h31,8'h00, 1,0,1,8'h30,8'h00, 1,0, 8'h88,8'h00);
    step(1, 0,0,0,8'h00,8'h00, 1,0,1,8'h30,8'h00, 0,1, 8'h00,8'h77);
    step(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 8'h00,8'h00);

    // Write on port 0 then read-back on port 1
    step(1, 1,1,0,8'h40,8'h3C, 0,0,0,8'h00,8'h00, 1,0, 8'h00,8'h00);
    step(1, 0,0,0,8'h00,8'h00, 1,0,0,8'h40,8'h5A, 0,1, 8'h00,8'h3C);
    step(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 8'h00,8'h00);

    // Port 0 locked, reset lands on a read request
    step(1, 1,0,1,8'h12,8'h00, 0,0,0,8'h00,8'h00, 1,0, 8'hA5,8'h00);
    step(1, 1,0,1,8'h12,8'h00, 0,0,0,8'h00,8'h00, 1,0, 8'hA5,8'h00);
    step(0, 1,0,1,8'h12,8'h00, 1,0,0,8'h21,8'h00, 0,0, 8'h00,8'h00);
    step(1, 1,0,0,8'h20,8'h00, 1,0,0,8'h21,8'h00, 1,0, 8'h11,8'h00);
    step(1, 1,0,0,8'h20,8'h00, 1,0,0,8'h21,8'h00, 0,1, 8'h00,8'h22);
    eflag = 1;
    step(1, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, 8'h00,8'h00);
    eflag = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
